// File: rtl/red_pitaya_mixer_pkg.sv
// Shared definitions for the signed matrix mixer: bus address map, saturation limits
// and the 14-bit saturation helper.
package red_pitaya_mixer_pkg;

    localparam logic [15:0] GAIN_BASE  = 16'h0100;
    localparam logic [15:0] OFFS_BASE  = 16'h0180;
    localparam logic [15:0] STEP_ADDR  = 16'h01A0;
    localparam logic [15:0] STAT_ADDR  = 16'h01A4;
    localparam logic [15:0] PSR_ADDR   = 16'h0200;
    localparam logic [15:0] GBITS_ADDR = 16'h020C;
    localparam logic [15:0] NIN_ADDR   = 16'h0210;
    localparam logic [15:0] NOUT_ADDR  = 16'h0214;

    localparam logic signed [63:0] SAT_HI = 64'sd8191;
    localparam logic signed [63:0] SAT_LO = -64'sd8192;

    function automatic logic signed [13:0] sat14(input logic signed [63:0] x);
        logic signed [13:0] y;
        if (x > SAT_HI) begin
            y = 14'h1FFF;
        end else if (x < SAT_LO) begin
            y = 14'h2000;
        end else begin
            y = x[13:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/red_pitaya_gain_ramp.sv
// One mixer coefficient: the current gain slews linearly toward the target by at most
// step per cycle, or jumps straight to it when step is zero.
module red_pitaya_gain_ramp #(
    parameter int unsigned GAINBITS = 24,
    parameter int unsigned RAMPBITS = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [GAINBITS-1:0] tgt_i,
    input  logic [RAMPBITS-1:0] step_i,
    output logic [GAINBITS-1:0] cur_o,
    output logic                busy_o
);

    localparam int unsigned W = GAINBITS + 1;

    logic [GAINBITS-1:0]  cur_q, cur_d;
    logic signed [W-1:0]  diff, mag, step_ext;

    // One extra bit keeps tgt-cur exact across the full signed range.
    always_comb begin
        diff     = W'($signed(tgt_i)) - W'($signed(cur_q));
        mag      = diff[W-1] ? -diff : diff;
        step_ext = W'(step_i);
        cur_d    = cur_q;
        if (step_i == '0 || mag <= step_ext) begin
            cur_d = tgt_i;
        end else if (diff[W-1]) begin
            cur_d = cur_q - step_ext[GAINBITS-1:0];
        end else begin
            cur_d = cur_q + step_ext[GAINBITS-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign cur_o  = cur_q;
    assign busy_o = (cur_q != tgt_i);

endmodule

// File: rtl/red_pitaya_mixer_block.sv
// NIN x NOUT signed matrix mixer with slewed gains, per-output offset and 14-bit
// saturation, behind a simple register bus.
module red_pitaya_mixer_block
    import red_pitaya_mixer_pkg::*;
#(
    parameter int unsigned NIN      = 4,
    parameter int unsigned NOUT     = 2,
    parameter int unsigned GAINBITS = 24,
    parameter int unsigned PSR      = 12,
    parameter int unsigned RAMPBITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [14*NIN-1:0]    dat_i,
    output logic [14*NOUT-1:0]   dat_o,
    output logic [NOUT-1:0]      ramping_o,
    input  logic [15:0]          addr,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [31:0]          wdata,
    output logic                 ack,
    output logic [31:0]          rdata
);

    localparam int unsigned NG = NIN * NOUT;
    localparam int unsigned PW = 14 + GAINBITS;
    localparam int unsigned AW = PW + $clog2(NIN);

    logic [GAINBITS-1:0]   tgt_q [NG];
    logic [GAINBITS-1:0]   cur   [NG];
    logic [NG-1:0]         busy;
    logic signed [13:0]    offs_q [NOUT];
    logic [RAMPBITS-1:0]   step_q;
    logic [NOUT-1:0]       ramping_d, ramping_q;
    logic signed [PW-1:0]  prod_q [NG];
    logic signed [AW-1:0]  acc_d [NOUT];
    logic signed [AW-1:0]  acc_q [NOUT];
    logic [14*NOUT-1:0]    dat_q;
    logic                  ack_q;
    logic [31:0]           rdata_d, rdata_q;
    logic                  unused_wdata;

    assign unused_wdata = ^wdata[31:GAINBITS];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NG; k++) begin
                tgt_q[k] <= '0;
            end
            for (int o = 0; o < NOUT; o++) begin
                offs_q[o] <= '0;
            end
            step_q <= '0;
        end else if (wen) begin
            for (int k = 0; k < NG; k++) begin
                if (addr == GAIN_BASE + 16'(4 * k)) begin
                    tgt_q[k] <= wdata[GAINBITS-1:0];
                end
            end
            for (int o = 0; o < NOUT; o++) begin
                if (addr == OFFS_BASE + 16'(4 * o)) begin
                    offs_q[o] <= wdata[13:0];
                end
            end
            if (addr == STEP_ADDR) begin
                step_q <= wdata[RAMPBITS-1:0];
            end
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_ramp
        red_pitaya_gain_ramp #(
            .GAINBITS (GAINBITS),
            .RAMPBITS (RAMPBITS)
        ) u_ramp (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .tgt_i  (tgt_q[k]),
            .step_i (step_q),
            .cur_o  (cur[k]),
            .busy_o (busy[k])
        );
    end

    always_comb begin
        ramping_d = '0;
        for (int o = 0; o < NOUT; o++) begin
            for (int i = 0; i < NIN; i++) begin
                ramping_d[o] = ramping_d[o] | busy[o*NIN+i];
            end
        end
    end

    // Target reads return the programmed target, not the slewing value.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NG; k++) begin
            if (addr == GAIN_BASE + 16'(4 * k)) begin
                rdata_d = 32'($signed(tgt_q[k]));
            end
        end
        for (int o = 0; o < NOUT; o++) begin
            if (addr == OFFS_BASE + 16'(4 * o)) begin
                rdata_d = 32'(offs_q[o]);
            end
        end
        case (addr)
            STEP_ADDR:  rdata_d = 32'(step_q);
            STAT_ADDR:  rdata_d = 32'(ramping_q);
            PSR_ADDR:   rdata_d = 32'(PSR);
            GBITS_ADDR: rdata_d = 32'(GAINBITS);
            NIN_ADDR:   rdata_d = 32'(NIN);
            NOUT_ADDR:  rdata_d = 32'(NOUT);
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            ramping_q <= '0;
        end else begin
            ack_q     <= wen | ren;
            rdata_q   <= ren ? rdata_d : '0;
            ramping_q <= ramping_d;
        end
    end

    always_comb begin
        for (int o = 0; o < NOUT; o++) begin
            acc_d[o] = '0;
            for (int i = 0; i < NIN; i++) begin
                acc_d[o] = acc_d[o] + AW'(prod_q[o*NIN+i]);
            end
        end
    end

    // Multiply, accumulate, then shift/offset/saturate: one register per stage.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NG; k++) begin
                prod_q[k] <= '0;
            end
            for (int o = 0; o < NOUT; o++) begin
                acc_q[o] <= '0;
            end
            dat_q <= '0;
        end else begin
            for (int k = 0; k < NG; k++) begin
                prod_q[k] <= PW'($signed(dat_i[14*(k%NIN)+:14])) * PW'($signed(cur[k]));
            end
            for (int o = 0; o < NOUT; o++) begin
                acc_q[o]          <= acc_d[o];
                dat_q[14*o+:14]   <= sat14(64'(acc_q[o] >>> PSR) + 64'(offs_q[o]));
            end
        end
    end

    assign dat_o     = dat_q;
    assign ramping_o = ramping_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_red_pitaya_mixer_block.sv
// Directed and randomized bench for the matrix mixer, checked each cycle against a
// behavioural model of gains, latency, saturation and the register map.
module tb_red_pitaya_mixer_block;

    localparam int NIN  = 4;
    localparam int NOUT = 2;
    localparam int GB   = 24;
    localparam int PSR  = 12;
    localparam int RB   = 16;
    localparam int NG   = NIN * NOUT;

    logic                clk = 1'b0;
    logic                rstn;
    logic [14*NIN-1:0]   dat_i;
    logic [14*NOUT-1:0]  dat_o;
    logic [NOUT-1:0]     ramping;
    logic [15:0]         addr;
    logic                wen, ren;
    logic [31:0]         wdata;
    logic                ack;
    logic [31:0]         rdata;

    int tests = 0;
    int fails = 0;

    logic signed [13:0] in_m [NIN];
    int          tgt_m [NG];
    int          cur_m [NG];
    int          offs_m [NOUT];
    int          step_m;
    longint      pa [NOUT];
    longint      pb [NOUT];
    logic [13:0] exp_dat [NOUT];
    logic [NOUT-1:0] exp_ramp;
    logic        exp_ack;
    logic        rd_chk;
    logic [31:0] exp_rd, exp_rmask;

    always #5 clk = ~clk;

    always_comb begin
        dat_i = '0;
        for (int i = 0; i < NIN; i++) dat_i[14*i+:14] = in_m[i];
    end

    red_pitaya_mixer_block #(
        .NIN(NIN), .NOUT(NOUT), .GAINBITS(GB), .PSR(PSR), .RAMPBITS(RB)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .dat_i(dat_i), .dat_o(dat_o), .ramping_o(ramping),
        .addr(addr), .wen(wen), .ren(ren), .wdata(wdata), .ack(ack), .rdata(rdata)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ga(input int o, input int i);
        return 16'h0100 + 16'(4 * (o * NIN + i));
    endfunction

    function automatic int sat(input longint v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return int'(v);
    endfunction

    function automatic logic [31:0] rd_model(input logic [15:0] a);
        logic [31:0] v = '0;
        for (int k = 0; k < NG; k++) if (a == 16'h0100 + 16'(4 * k)) v = 32'(tgt_m[k]);
        for (int o = 0; o < NOUT; o++) if (a == 16'h0180 + 16'(4 * o)) v = 32'(offs_m[o]);
        if (a == 16'h01A0) v = 32'(step_m);
        if (a == 16'h01A4) v = 32'(exp_ramp);
        if (a == 16'h0200) v = PSR;
        if (a == 16'h020C) v = GB;
        if (a == 16'h0210) v = NIN;
        if (a == 16'h0214) v = NOUT;
        return v;
    endfunction

    function automatic logic [31:0] rd_mask(input logic [15:0] a);
        if (a >= 16'h0100 && a < 16'h0100 + 16'(4 * NG)) return 32'h00FF_FFFF;
        if (a >= 16'h0180 && a < 16'h0180 + 16'(4 * NOUT)) return 32'h0000_3FFF;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NG; k++) begin tgt_m[k] = 0; cur_m[k] = 0; end
        for (int o = 0; o < NOUT; o++) begin
            offs_m[o] = 0; pa[o] = 0; pb[o] = 0; exp_dat[o] = '0;
        end
        step_m = 0; exp_ramp = '0; exp_ack = 1'b0; rd_chk = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [31:0] d);
        for (int k = 0; k < NG; k++) if (a == 16'h0100 + 16'(4 * k)) tgt_m[k] = int'($signed(d[GB-1:0]));
        for (int o = 0; o < NOUT; o++) if (a == 16'h0180 + 16'(4 * o)) offs_m[o] = int'($signed(d[13:0]));
        if (a == 16'h01A0) step_m = int'(d[RB-1:0]);
    endtask

    // One clock: advance the model by the spec rules, then compare every output.
    task automatic tick();
        longint s;
        logic [NOUT-1:0] r;
        @(posedge clk);
        exp_ack = wen | ren;
        rd_chk  = ren;
        if (ren) begin exp_rd = rd_model(addr); exp_rmask = rd_mask(addr); end
        r = '0;
        for (int k = 0; k < NG; k++) if (cur_m[k] != tgt_m[k]) r[k / NIN] = 1'b1;
        exp_ramp = r;
        for (int o = 0; o < NOUT; o++) begin
            exp_dat[o] = 14'(sat((pa[o] >>> PSR) + longint'(offs_m[o])));
            s = 0;
            for (int i = 0; i < NIN; i++) s += longint'(in_m[i]) * longint'(cur_m[o*NIN+i]);
            pa[o] = pb[o];
            pb[o] = s;
        end
        for (int k = 0; k < NG; k++) begin
            int dd;
            dd = tgt_m[k] - cur_m[k];
            if (step_m == 0 || (dd < 0 ? -dd : dd) <= step_m) cur_m[k] = tgt_m[k];
            else cur_m[k] += (dd > 0) ? step_m : -step_m;
        end
        if (wen) model_write(addr, wdata);
        #1;
        for (int o = 0; o < NOUT; o++)
            check($sformatf("dat_o%0d", o), 32'(dat_o[14*o+:14]), 32'(exp_dat[o]));
        check("ramping_o", 32'(ramping), 32'(exp_ramp));
        check("ack", 32'(ack), 32'(exp_ack));
        if (rd_chk) check("rdata", rdata & exp_rmask, exp_rd & exp_rmask);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        addr = a; ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    initial begin
        int cnt, peak, v;
        rstn = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < NIN; i++) in_m[i] = '0;
        model_reset();
        #2;
        check("rst_dat_o", 32'(dat_o), 32'h0);
        check("rst_ramping", 32'(ramping), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // T1 pass-through
        in_m[0] = 14'sd1000;
        tick(); tick();
        wr(ga(0, 0), 32'h1000);
        tick(); tick(); tick();
        check("t1_before", 32'(dat_o[13:0]), 32'd0);
        tick();
        check("t1_out0", 32'(dat_o[13:0]), 32'd1000);
        check("t1_out1", 32'(dat_o[27:14]), 32'd0);

        // T2 sum and saturation
        for (int i = 1; i < NIN; i++) wr(ga(0, i), 32'h1000);
        for (int i = 0; i < NIN; i++) in_m[i] = 14'sd4000;
        repeat (4) tick();
        check("t2_pos_sat", 32'(dat_o[13:0]), 32'h1FFF);
        for (int i = 0; i < NIN; i++) in_m[i] = -14'sd4000;
        repeat (4) tick();
        check("t2_neg_sat", 32'(dat_o[13:0]), 32'h2000);

        // T3 slew; in1 = 4096 makes dat_o[0] equal to the current gain
        for (int i = 0; i < NIN; i++) in_m[i] = '0;
        in_m[1] = 14'sd4096;
        for (int i = 0; i < NIN; i++) wr(ga(0, i), 32'h0);
        repeat (4) tick();
        wr(16'h01A0, 32'h100);
        wr(ga(0, 1), 32'h1000);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ramping[0]) cnt++;
            else if (cnt > 0) break;
        end
        check("t3_ramp_len", 32'(cnt), 32'd16);
        repeat (3) tick();
        check("t3_settled", 32'(dat_o[13:0]), 32'h1000);
        wr(ga(0, 1), 32'h0);
        repeat (20) tick();
        wr(ga(0, 1), 32'h1000);
        repeat (9) tick();
        wr(ga(0, 1), 32'h0800);
        peak = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            v = int'($signed(dat_o[13:0]));
            if (v > peak) peak = v;
        end
        check("t3_peak", 32'(peak), 32'h0A00);
        check("t3_turned", 32'(dat_o[13:0]), 32'h0800);

        // T4 offset and floor shift
        wr(16'h01A0, 32'h0);
        in_m[1] = '0;
        in_m[0] = -14'sd3;
        wr(ga(1, 0), 32'h0800);
        wr(16'h0184, 32'd10);
        repeat (5) tick();
        check("t4_out1", 32'(dat_o[27:14]), 32'd8);

        // T5 bus
        rd(16'h0200); check("t5_psr", rdata, 32'd12); check("t5_ack", 32'(ack), 32'd1);
        rd(16'h020C); check("t5_gbits", rdata, 32'd24);
        rd(16'h0210); check("t5_nin", rdata, 32'd4);
        rd(16'h0214); check("t5_nout", rdata, 32'd2);
        rd(16'h0300); check("t5_unmapped", rdata, 32'd0);
        wr(16'h0200, 32'd99);
        rd(16'h0200); check("t5_ro_write", rdata, 32'd12);
        wr(16'h01A0, 32'h10);
        wr(ga(1, 1), 32'h100);
        tick();
        rd(16'h01A4); check("t5_status", rdata, 32'd2);
        rd(ga(1, 1)); check("t5_tgt_read", rdata & 32'h00FF_FFFF, 32'h100);
        wr(ga(1, 2), 32'h00FF_F000);
        rd(ga(1, 2)); check("t5_neg_gain", rdata & 32'h00FF_FFFF, 32'h00FF_F000);
        repeat (20) tick();

        // Randomized retuning with live inputs
        for (int r = 0; r < 6; r++) begin
            wr(16'h01A0, 32'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 512)));
            for (int k = 0; k < NG; k++) begin
                wr(16'h0100 + 16'(4 * k), 32'(int'($urandom_range(0, 3072)) - 1536));
                in_m[$urandom_range(0, NIN - 1)] = 14'($urandom);
            end
            for (int o = 0; o < NOUT; o++) wr(16'h0180 + 16'(4 * o), 32'(int'($urandom_range(0, 1000)) - 500));
            for (int c = 0; c < 20; c++) begin
                for (int i = 0; i < NIN; i++) in_m[i] = 14'($urandom);
                tick();
            end
        end

        // T6 reset during a slew
        wr(16'h01A0, 32'h0);
        for (int k = 0; k < NG; k++) wr(16'h0100 + 16'(4 * k), 32'h0);
        for (int i = 0; i < NIN; i++) in_m[i] = '0;
        in_m[1] = 14'sd4096;
        wr(ga(0, 1), 32'h0800);
        repeat (4) tick();
        wr(16'h01A0, 32'h100);
        wr(ga(0, 1), 32'h1000);
        repeat (3) tick();
        rd(16'h01A4);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_dat_o", 32'(dat_o), 32'h0);
        check("t6_ramping", 32'(ramping), 32'h0);
        check("t6_ack", 32'(ack), 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 0; k < NG; k++) begin
            rd(16'h0100 + 16'(4 * k));
            check($sformatf("t6_tgt%0d", k), rdata, 32'h0);
        end
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
